sr_flag_arbiter: RTL
====================

Name: sr_flag_arbiter

Overview:
- Controller that owns a bank of NUM_FLAGS SR flip-flops and shares it between two requesters, A and B.
- Each requester issues SET, CLR, TOGGLE or READ commands through a valid/ready handshake. Arbitration is round-robin.
- The block sequences the set/reset drive so that s=1 and r=1 never reach the same flop, which removes the invalid SR state by construction.
- Sits between software-visible status/control logic and the flag storage.

Parameters:
NUM_FLAGS, 8, number of SR flags in the bank (2..256)
IDX_W, $clog2(NUM_FLAGS), width of the flag index field

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
a_valid  input  1  requester A command valid
a_ready  output  1  requester A command accepted this cycle
a_op  input  2  requester A opcode
a_idx  input  IDX_W  requester A flag index
a_done  output  1  one-cycle completion pulse to A
a_err  output  1  qualifies a_done; index out of range
a_rdata  output  1  flag value after the command, valid with a_done
b_valid, b_ready, b_op, b_idx, b_done, b_err, b_rdata  same as A, for requester B
flags  output  NUM_FLAGS  current q of every flop in the bank

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, flags=0, prio=A, every ready/done/err/rdata=0. Asserting reset mid-command aborts the command: no done pulse, flags cleared.
- Opcodes: SET=2'b00, CLR=2'b01, TGL=2'b10, READ=2'b11.
- FSM states: IDLE, EXEC, DONE. Transitions: IDLE→EXEC on handshake; EXEC→DONE always; DONE→IDLE always.
- IDLE state:
  - Ready is combinational and asserts only in IDLE.
  - Only one requester valid: grant it.
  - Both valid: grant prio.
  - Handshake is valid&&ready. It captures op, idx and owner.
  - prio flips to the non-granted requester after every grant.
- EXEC state:
  - Drive one-hot s_vec/r_vec to the bank for exactly one cycle.
  - SET → s[idx]=1. CLR → r[idx]=1.
  - TGL → s[idx]=~q[idx], r[idx]=q[idx].
  - READ, or idx≥NUM_FLAGS → s_vec=r_vec=0.
  - The bank updates at the end of EXEC.
- DONE state:
  - Pulse owner's done for one cycle.
  - rdata=flags[idx] (updated value), or 0 on err.
  - err=1 iff idx≥NUM_FLAGS.
- Timing: handshake at cycle T → flags updated visible at T+2, done at T+2. Next accept no earlier than T+3. Throughput is 1 command per 3 cycles.
- Requester rules: valid is held until ready. op/idx are stable while valid. Deasserting valid before ready is a protocol error; the block does not detect it.
- Outputs a_* and b_* are never asserted toward the non-owner.
- Invariants, with assertions in RTL:
  - (s_vec & r_vec)==0 every cycle.
  - popcount(s_vec|r_vec)≤1.
  - a_ready&b_ready never both 1.
  - a_done&b_done never both 1.

Decomposition:
- Package sr_flag_pkg holds:
  - opcode localparams OP_SET, OP_CLR, OP_TGL, OP_READ;
  - FSM state encoding ST_IDLE, ST_EXEC, ST_DONE;
  - requester id constants REQ_A, REQ_B.
- Sub-module sr_flag_bank:
  - NUM_FLAGS SR flops with clk and synchronous active-low rst_n.
  - Inputs s_vec/r_vec; output q.
  - s=1,r=0→1. s=0,r=1→0. 00→hold. 11 is unreachable (asserted).
- Top level holds the arbiter, the FSM and the s/r encode logic.

Test Plan:
- Reset then A SET idx=3 → a_ready at cycle 0, a_done at +2, a_rdata=1, flags=8'h08, b_done stays 0.
- A and B both valid from reset, A SET 1, B SET 2 → A granted first (prio=A), B granted at +3. flags=8'h06 after B done. prio ends =A.
- Flags=8'h05, B TGL idx=0 then TGL idx=1 → after first command flags=8'h04, b_rdata=0. After second flags=8'h06, b_rdata=1. Check s&r==0 in every cycle.
- A READ idx=2 with flags=8'h04 → a_rdata=1, a_err=0, flags unchanged. NUM_FLAGS=6, A SET idx=7 → a_err=1, a_rdata=0, flags unchanged.
- Both requesters continuously valid for 10 commands → grants alternate A,B,A,B…, each ready one cycle, 3-cycle spacing.
- A SET idx=5 accepted, rst_n=0 during EXEC → no a_done, flags=0 on next cycle, state IDLE. After release, B CLR 5 completes with b_rdata=0.

Source files
------------

// File: rtl/sr_flag_pkg.sv
// Shared encodings for the SR flag arbiter: opcodes, controller states and requester ids.
package sr_flag_pkg;

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_TGL  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Round-robin pointer moves to whichever requester was not just served.
    function automatic logic next_prio(input logic granted);
        return (granted == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/sr_flag_bank.sv
// Bank of NUM_FLAGS set/reset flops; s=r=1 is kept out by the controller.
module sr_flag_bank
    import sr_flag_pkg::*;
#(
    parameter int NUM_FLAGS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_FLAGS-1:0] s_vec,
    input  logic [NUM_FLAGS-1:0] r_vec,
    output logic [NUM_FLAGS-1:0] q
);

    logic [NUM_FLAGS-1:0] q_q;
    logic [NUM_FLAGS-1:0] q_d;

    always_comb begin
        q_d = (q_q | s_vec) & ~r_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

    a_no_sr_clash: assert property (@(posedge clk) disable iff (!rst_n)
        (s_vec & r_vec) == '0);

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter sharing an SR flag bank between requesters A and B.
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int NUM_FLAGS = 8,
    parameter int IDX_W     = $clog2(NUM_FLAGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [1:0]           a_op,
    input  logic [IDX_W-1:0]     a_idx,
    output logic                 a_done,
    output logic                 a_err,
    output logic                 a_rdata,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [1:0]           b_op,
    input  logic [IDX_W-1:0]     b_idx,
    output logic                 b_done,
    output logic                 b_err,
    output logic                 b_rdata,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam logic [IDX_W:0] NF_LIM = NUM_FLAGS[IDX_W:0];

    logic [1:0]           state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 owner_q, owner_d;
    logic [1:0]           op_q, op_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic                 grant_a;
    logic                 grant_b;
    logic                 idx_ok;
    logic                 in_done;
    logic                 rd_bit;
    logic [NUM_FLAGS-1:0] s_vec;
    logic [NUM_FLAGS-1:0] r_vec;

    // Ready doubles as the grant, so only the winner ever sees it.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == ST_IDLE) begin
            if (a_valid && (!b_valid || prio_q == REQ_A)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        op_d    = op_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_a || grant_b) begin
                    state_d = ST_EXEC;
                    owner_d = grant_b ? REQ_B : REQ_A;
                    op_d    = grant_b ? b_op : a_op;
                    idx_d   = grant_b ? b_idx : a_idx;
                    prio_d  = next_prio(grant_b ? REQ_B : REQ_A);
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= REQ_A;
            owner_q <= REQ_A;
            op_q    <= OP_READ;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
        end
    end

    assign idx_ok = ({1'b0, idx_q} < NF_LIM);

    // Toggle drives exactly one of s/r from the current q, never both.
    always_comb begin
        s_vec = '0;
        r_vec = '0;
        if (state_q == ST_EXEC && idx_ok) begin
            case (op_q)
                OP_SET: s_vec[idx_q] = 1'b1;
                OP_CLR: r_vec[idx_q] = 1'b1;
                OP_TGL: begin
                    s_vec[idx_q] = ~flags[idx_q];
                    r_vec[idx_q] = flags[idx_q];
                end
                OP_READ: begin
                end
                default: begin
                end
            endcase
        end
    end

    sr_flag_bank #(
        .NUM_FLAGS(NUM_FLAGS)
    ) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .s_vec(s_vec),
        .r_vec(r_vec),
        .q    (flags)
    );

    always_comb begin
        in_done = (state_q == ST_DONE);
        rd_bit  = idx_ok ? flags[idx_q] : 1'b0;
        a_done  = in_done && (owner_q == REQ_A);
        b_done  = in_done && (owner_q == REQ_B);
        a_err   = a_done && !idx_ok;
        b_err   = b_done && !idx_ok;
        a_rdata = a_done && rd_bit;
        b_rdata = b_done && rd_bit;
    end

    a_sr_disjoint: assert property (@(posedge clk) disable iff (!rst_n)
        (s_vec & r_vec) == '0);
    a_sr_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(s_vec | r_vec));
    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(a_ready && b_ready));
    a_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(a_done && b_done));

endmodule
